// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory bus with programmable wait states.
// Define ARB_FIXED_PRIO_EN to give master 0 fixed priority instead of round-robin.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        gnt,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt_d;
  logic              bus_rd_d, bus_wr_d, busy_d, m0_ack_d, m1_ack_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic              win_c;

  // Winner index (1 = master 1), meaningful only when some request is up
`ifdef ARB_FIXED_PRIO_EN
  assign win_c = ~m0_req;
`else
  assign win_c = (m0_req & m1_req) ? ~last_owner_q : m1_req;
`endif

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rdata_d      = rdata_q;
    gnt_d        = gnt;
    busy_d       = busy;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    bus_rd_d     = 1'b0;
    bus_wr_d     = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d     = ACCESS;
          owner_d     = win_c;
          we_d        = win_c ? m1_we : m0_we;
          bus_addr_d  = win_c ? m1_addr : m0_addr;
          bus_wdata_d = win_c ? m1_wdata : m0_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          gnt_d       = win_c ? 2'b10 : 2'b01;
          bus_rd_d    = ~we_d;
          bus_wr_d    = we_d;
          busy_d      = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          if (!we_q) rdata_d = bus_rdata;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          bus_rd_d = ~we_q;
          bus_wr_d = we_q;
        end
      end
      RESP: begin
        state_d      = IDLE;
        gnt_d        = 2'b00;
        busy_d       = 1'b0;
        last_owner_d = owner_q;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 2'b00;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rdata_q      <= '0;
      gnt          <= 2'b00;
      busy         <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_rd       <= 1'b0;
      bus_wr       <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rdata_q      <= rdata_d;
      gnt          <= gnt_d;
      busy         <= busy_d;
      bus_addr     <= bus_addr_d;
      bus_wdata    <= bus_wdata_d;
      bus_rd       <= bus_rd_d;
      bus_wr       <= bus_wr_d;
      m0_ack       <= m0_ack_d;
      m1_ack       <= m1_ack_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance a uses WAIT_CYCLES=1, instance b uses WAIT_CYCLES=0,
// each checked every cycle against a transaction-schedule reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];

  logic          ack0_a, ack1_a, rd_a, wr_a, busy_a;
  logic          ack0_b, ack1_b, rd_b, wr_b, busy_b;
  logic [1:0]    gnt_a, gnt_b;
  logic [DW-1:0] rdata0_a, rdata1_a, bwdata_a, brdata_a;
  logic [DW-1:0] rdata0_b, rdata1_b, bwdata_b, brdata_b;
  logic [AW-1:0] baddr_a, baddr_b;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    if (a == 32'h40) return 32'hA5A5_A5A5;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F;
  endfunction

  assign brdata_a = mem_val(baddr_a);
  assign brdata_b = mem_val(baddr_b);

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_ack(ack0_a), .m0_rdata(rdata0_a),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_ack(ack1_a), .m1_rdata(rdata1_a),
    .bus_rd(rd_a), .bus_wr(wr_a), .bus_addr(baddr_a), .bus_wdata(bwdata_a),
    .bus_rdata(brdata_a), .gnt(gnt_a), .busy(busy_a));

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_ack(ack0_b), .m0_rdata(rdata0_b),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_ack(ack1_b), .m1_rdata(rdata1_b),
    .bus_rd(rd_b), .bus_wr(wr_b), .bus_addr(baddr_b), .bus_wdata(bwdata_b),
    .bus_rdata(brdata_b), .gnt(gnt_b), .busy(busy_b));

  logic [1:0]  o_gnt   [2];
  logic        o_rd    [2];
  logic        o_wr    [2];
  logic        o_busy  [2];
  logic        o_ack   [2][2];
  logic [31:0] o_rdata [2][2];
  logic [31:0] o_baddr [2];
  logic [31:0] o_bwdata[2];

  always_comb begin
    o_gnt[0] = gnt_a;       o_gnt[1] = gnt_b;
    o_rd[0] = rd_a;         o_rd[1] = rd_b;
    o_wr[0] = wr_a;         o_wr[1] = wr_b;
    o_busy[0] = busy_a;     o_busy[1] = busy_b;
    o_ack[0][0] = ack0_a;   o_ack[0][1] = ack1_a;
    o_ack[1][0] = ack0_b;   o_ack[1][1] = ack1_b;
    o_rdata[0][0] = rdata0_a; o_rdata[0][1] = rdata1_a;
    o_rdata[1][0] = rdata0_b; o_rdata[1][1] = rdata1_b;
    o_baddr[0] = baddr_a;   o_baddr[1] = baddr_b;
    o_bwdata[0] = bwdata_a; o_bwdata[1] = bwdata_b;
  end

  int tests, fails, cyc;
  bit rnd, hold;

  // Reference model: one scheduled transaction per instance
  bit          m_act  [2];
  int          m_start[2];
  bit          m_own  [2];
  bit          m_we   [2];
  bit          m_last [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rdata[2];
  bit          acked  [2][2];
  int          last_ack[2][2];
  int          rd_cnt [2];
  int          wr_cnt [2];
  int          ack_log[$];

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL dut%0d %s observed=%h expected=%h", d, tag, obs, exp);
    end
  endtask

  task automatic model_check(input int d);
    int  w;
    bit  acc, rsp, win;
    w = (d == 0) ? 1 : 0;
    if (m_act[d] && cyc > m_start[d] + 2 + w) m_act[d] = 1'b0;
    acc = m_act[d] && (cyc >= m_start[d] + 1) && (cyc <= m_start[d] + 1 + w);
    rsp = m_act[d] && (cyc == m_start[d] + 2 + w);
    if (rsp && !m_we[d]) m_rdata[d] = mem_val(m_addr[d]);
    chk(d, "gnt", 32'(o_gnt[d]), 32'((acc || rsp) ? (m_own[d] ? 2'b10 : 2'b01) : 2'b00));
    chk(d, "bus_rd", 32'(o_rd[d]), 32'(acc && !m_we[d]));
    chk(d, "bus_wr", 32'(o_wr[d]), 32'(acc && m_we[d]));
    chk(d, "busy", 32'(o_busy[d]), 32'(acc || rsp));
    chk(d, "ack0", 32'(o_ack[d][0]), 32'(rsp && !m_own[d]));
    chk(d, "ack1", 32'(o_ack[d][1]), 32'(rsp && m_own[d]));
    chk(d, "rdata0", o_rdata[d][0], m_rdata[d]);
    chk(d, "rdata1", o_rdata[d][1], m_rdata[d]);
    if (acc) begin
      chk(d, "bus_addr", o_baddr[d], m_addr[d]);
      chk(d, "bus_wdata", o_bwdata[d], m_wdata[d]);
    end
    acked[d][0] = rsp && !m_own[d];
    acked[d][1] = rsp && m_own[d];
    for (int m = 0; m < 2; m++)
      if (o_ack[d][m] === 1'b1) begin
        last_ack[d][m] = cyc;
        if (d == 0) ack_log.push_back(m);
      end
    if (o_rd[d] === 1'b1) rd_cnt[d]++;
    if (o_wr[d] === 1'b1) wr_cnt[d]++;
    if (!m_act[d] && (req[d][0] || req[d][1])) begin
`ifdef ARB_FIXED_PRIO_EN
      win = !req[d][0];
`else
      win = (req[d][0] && req[d][1]) ? !m_last[d] : req[d][1];
`endif
      m_act[d] = 1'b1;   m_start[d] = cyc;   m_own[d] = win;   m_last[d] = win;
      m_we[d] = we[d][win]; m_addr[d] = addr[d][win]; m_wdata[d] = wdata[d][win];
    end
  endtask

  task automatic update_stim(input int d, input int m);
    if (rnd) begin
      if (acked[d][m] || !req[d][m]) begin
        req[d][m]   = ($urandom_range(0, 3) != 0);
        we[d][m]    = 1'($urandom_range(0, 1));
        addr[d][m]  = $urandom & 32'h0000_0FFC;
        wdata[d][m] = $urandom;
      end
    end else if (acked[d][m] && !hold) begin
      req[d][m] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_check(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) update_stim(d, m);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset mid-cycle; strobes, grant and acks must drop without a clock edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_bus_rd", 32'(o_rd[d]), 32'd0);
      chk(d, "rst_bus_wr", 32'(o_wr[d]), 32'd0);
      chk(d, "rst_gnt", 32'(o_gnt[d]), 32'd0);
      chk(d, "rst_acks", 32'({o_ack[d][1], o_ack[d][0]}), 32'd0);
      m_act[d] = 1'b0; m_last[d] = 1'b1; m_rdata[d] = '0;
      for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  int t;
  int exp_seq[4];

  initial begin
    tests = 0; fails = 0; cyc = 0; rnd = 1'b0; hold = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = 0; wr_cnt[d] = 0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
        acked[d][m] = 1'b0; last_ack[d][m] = -1;
      end
    end
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_rdata", o_rdata[d][0], 32'd0);
      chk(d, "rst_bus_addr", o_baddr[d], 32'd0);
      chk(d, "rst_busy", 32'(o_busy[d]), 32'd0);
    end

    // m0 read of 0x10
    rd_cnt[0] = 0;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h10; wdata[0][0] = 32'h0;
    t = cyc;
    steps(5);
    chk(0, "t1_ack_cycle", 32'(last_ack[0][0]), 32'(t + 3));
    chk(0, "t1_rd_cycles", 32'(rd_cnt[0]), 32'd2);
    chk(0, "t1_rdata", o_rdata[0][0], 32'hDEAD_BEEF);

    // m1 write of 0x12345678 to 0x20
    rd_cnt[0] = 0; wr_cnt[0] = 0;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 32'h20; wdata[0][1] = 32'h1234_5678;
    t = cyc;
    steps(5);
    chk(0, "t2_ack_cycle", 32'(last_ack[0][1]), 32'(t + 3));
    chk(0, "t2_wr_cycles", 32'(wr_cnt[0]), 32'd2);
    chk(0, "t2_rd_cycles", 32'(rd_cnt[0]), 32'd0);
    chk(0, "t2_rdata_kept", o_rdata[0][1], 32'hDEAD_BEEF);

    // both masters held from reset
    do_reset();
    ack_log.delete();
    hold = 1'b1;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h100;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 32'h104;
    steps(16);
    hold = 1'b0;
    req[0][0] = 1'b0; req[0][1] = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    chk(0, "t3_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) chk(0, "t3_grant_order", 32'(ack_log[i]), 32'(exp_seq[i]));
    steps(2);

    // m0 address changes during ACCESS
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h10;
    steps(2);
    addr[0][0] = 32'h30;
    step();
    chk(0, "t4_addr_held", o_baddr[0], 32'h10);
    steps(3);

    // reset in second ACCESS cycle of an m1 write
    ack_log.delete();
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 32'h24; wdata[0][1] = 32'hCAFE_0001;
    steps(2);
    chk(0, "t5_wr_before_rst", 32'(o_wr[0]), 32'd1);
    do_reset();
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h44;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 32'h48; wdata[0][1] = 32'h0BAD_F00D;
    steps(9);
    chk(0, "t5_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      chk(0, "t5_first_winner", 32'(ack_log[0]), 32'd0);
      chk(0, "t5_second_winner", 32'(ack_log[1]), 32'd1);
    end

    // zero wait states: m1 read of 0x40
    rd_cnt[1] = 0;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'h40;
    t = cyc;
    steps(4);
    chk(1, "t6_ack_cycle", 32'(last_ack[1][1]), 32'(t + 2));
    chk(1, "t6_rd_cycles", 32'(rd_cnt[1]), 32'd1);
    chk(1, "t6_rdata", o_rdata[1][1], 32'hA5A5_A5A5);

    // randomized traffic on both instances
    rnd = 1'b1;
    steps(600);
    rnd = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
    steps(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared data-memory/device bus (read strobe, write strobe, address, write data, read data).
- Master 0 is the CPU data port. Master 1 is a secondary requester (DMA/loader).
- Serialises accesses, applies a programmable bus wait-state count, and returns read data plus a one-cycle acknowledge to the winning master.
- Sits between the CPU memory-control logic and the data memory / peripheral decode.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, extra bus cycles per access beyond the first (0..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- m0_req  input  1  master 0 access request, level, held until m0_ack
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  ADDR_W  master 0 address
- m0_wdata  input  DATA_W  master 0 write data
- m0_ack  output  1  master 0 completion pulse
- m0_rdata  output  DATA_W  master 0 read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata  inputs  1/1/ADDR_W/DATA_W  master 1, same semantics as master 0
- m1_ack  output  1  master 1 completion pulse
- m1_rdata  output  DATA_W  master 1 read data, valid with m1_ack
- bus_rd  output  1  bus read strobe
- bus_wr  output  1  bus write strobe
- bus_addr  output  ADDR_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_rdata  input  DATA_W  bus read data, combinational from memory
- gnt  output  2  one-hot current owner; 00 when idle
- busy  output  1  high in ACCESS or RESP

Behaviour:
- Reset values: state IDLE; gnt=00; acks=0; bus_rd=bus_wr=0; bus_addr/bus_wdata/rdata register=0; last_owner=1 (so master 0 wins the first tie).
- FSM states:
  - IDLE: sample both req. If none, stay. Else pick a winner, latch its we/addr/wdata into internal registers, load wait counter with WAIT_CYCLES, set gnt, go to ACCESS.
  - ACCESS: bus_rd = ~we_latched, bus_wr = we_latched; bus_addr/bus_wdata come from the latched registers, stable for the whole access.
    - Counter decrements each cycle.
    - When counter==0: if read, capture bus_rdata into the rdata register at that edge; go to RESP.
    - Duration is WAIT_CYCLES+1 cycles.
  - RESP: strobes low; winner's ack=1 for exactly this cycle; gnt held; go to IDLE. last_owner updates to the winner.
- Latency: request first seen high in IDLE at cycle t → ACCESS t+1 .. t+1+WAIT_CYCLES → ack at t+2+WAIT_CYCLES.
- Arbitration (default): round-robin. On a tie, the master that is not last_owner wins. A single requester always wins.
- Handshake rules:
  - A master keeps req and its fields stable until its ack.
  - req still high in the IDLE cycle after ack is a new request.
  - Inputs changing after grant have no effect (latched).
- Strobes: bus_rd and bus_wr are never both high and are low outside ACCESS. A write leaves the rdata register unchanged.
- m0_rdata and m1_rdata both drive from the shared rdata register. Acks are never high simultaneously.
- Minimum inter-access gap: one IDLE cycle.
- Master 0 back-to-back with master 1 contending alternates owners.
- WAIT_CYCLES=0: ACCESS lasts 1 cycle.
- Reset mid-ACCESS or mid-RESP: immediate return to IDLE, strobes drop asynchronously, no ack issued, transaction discarded.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins ties in IDLE; last_owner unused. Master 1 is served only when m0_req is low in IDLE.
- Undefined: round-robin as above.

Test Plan:
- Reset then m0 read, WAIT_CYCLES=1, addr 0x10, bus_rdata=0xDEADBEEF → bus_rd high 2 cycles, addr 0x10; m0_ack 1 cycle at t+3; m0_rdata=0xDEADBEEF; gnt=01 during access.
- m1 write addr 0x20, data 0x12345678 → bus_wr high 2 cycles with those values; m1_ack at t+3; rdata register unchanged; bus_rd never high.
- Both req high from reset, held continuously → grant order m0, m1, m0, m1; each access 4 cycles incl. IDLE gap; acks alternate. With ARB_FIXED_PRIO_EN: m0 every time, m1_ack never.
- m0 changes addr 0x10→0x30 during ACCESS → bus_addr stays 0x10 through ACCESS.
- Reset asserted in 2nd ACCESS cycle → bus_rd/bus_wr 0 immediately; no ack; gnt=00; next request served normally, m0 winning a tie.
- WAIT_CYCLES=0, single m1 read of 0xA5A5A5A5 → bus_rd exactly 1 cycle; m1_ack at t+2 with m1_rdata=0xA5A5A5A5.
